// File: rtl/wb_write_arbiter_if.sv
// Bundles the write-arbiter bus: WB writeback, long-latency results, issue/decode checks, RF port.
// Pure wiring, no latency.
// lu_valid/lu_ready is a valid-ready pair; the WB source has no backpressure.
interface wb_write_arbiter_if #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_addr;
    logic [DW-1:0] lu_data;
    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic          chk_en1;
    logic          chk_en2;
    logic          chk_den;
    logic [AW-1:0] chk_addr1;
    logic [AW-1:0] chk_addr2;
    logic [AW-1:0] chk_dst;
    logic          stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [CW-1:0] fifo_cnt;
    logic          err;

    modport master (
        output wb_we, wb_addr, wb_data,
        output lu_valid, lu_addr, lu_data,
        output iss_valid, iss_addr,
        output chk_en1, chk_en2, chk_den, chk_addr1, chk_addr2, chk_dst,
        input  lu_ready, stall, rf_we, rf_waddr, rf_wdata, fifo_cnt, err
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  lu_valid, lu_addr, lu_data,
        input  iss_valid, iss_addr,
        input  chk_en1, chk_en2, chk_den, chk_addr1, chk_addr2, chk_dst,
        output lu_ready, stall, rf_we, rf_waddr, rf_wdata, fifo_cnt, err
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Single RF write port shared by WB writeback (priority) and buffered long-latency results; busy scoreboard + stall.
// One cycle from winning source to rf_*; stall and lu_ready are combinational from registered state.
// lu_ready drops when the result FIFO is full; WB writeback is never stalled, so the FIFO drains only on WB-idle cycles.
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    wb_write_arbiter_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int NREG = 1 << AW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Result FIFO storage and control
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    // Scoreboard and sticky error
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            err_q;

    // Registered write port
    logic          rf_we_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;

    logic          fifo_empty;
    logic          accept;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          lu_wr;
    logic [AW-1:0] lu_wr_addr;
    logic [DW-1:0] lu_wr_data;
    logic          err_set;

    assign fifo_empty   = (cnt == '0);
    assign bus.lu_ready = (cnt < FULL_CNT);
    assign accept       = bus.lu_valid & bus.lu_ready;

    // WB wins; otherwise the oldest buffered result; otherwise a fresh result goes straight through.
    assign pop    = ~bus.wb_we & ~fifo_empty;
    assign bypass = ~bus.wb_we & fifo_empty & accept;
    assign push   = accept & ~bypass;

    assign lu_wr      = pop | bypass;
    assign lu_wr_addr = pop ? mem_addr[rd_ptr] : bus.lu_addr;
    assign lu_wr_data = pop ? mem_data[rd_ptr] : bus.lu_data;

    // Hazard stall only sees registered busy bits; a same-cycle issue shows up next cycle.
    assign bus.stall = (bus.chk_en1 & busy[bus.chk_addr1])
                     | (bus.chk_en2 & busy[bus.chk_addr2])
                     | (bus.chk_den & busy[bus.chk_dst]);

    // Protocol violations: double issue, WAW that slipped past the stall, orphan long-latency write.
    assign err_set = (bus.iss_valid & busy[bus.iss_addr])
                   | (bus.wb_we & busy[bus.wb_addr])
                   | (lu_wr & ~busy[lu_wr_addr]);

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.fifo_cnt = cnt;
    assign bus.err      = err_q;

    // Next scoreboard: clear on long-latency write, then set on issue so set wins on a collision.
    always_comb begin
        busy_nxt = busy;
        if (lu_wr) begin
            busy_nxt[lu_wr_addr] = 1'b0;
        end
        if (bus.iss_valid) begin
            busy_nxt[bus.iss_addr] = 1'b1;
        end
    end

    // Register-file write port; address/data hold on idle cycles.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (bus.wb_we) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= bus.wb_addr;
            rf_wdata_q <= bus.wb_data;
        end else if (lu_wr) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= lu_wr_addr;
            rf_wdata_q <= lu_wr_data;
        end else begin
            rf_we_q    <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO payload storage; contents are meaningless while not counted, so no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr[wr_ptr] <= bus.lu_addr;
            mem_data[wr_ptr] <= bus.lu_data;
        end
    end

    // Scoreboard and sticky error register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule
